flex_counter_sched: RTL and testbench

Sequencer and round-robin arbiter that shares one `flex_counter` instance among `NUM_REQ` requesters as a programmable-interval timer. Each requester raises `req` with its interval in `period`. The block grants the counter to one requester at a time, drives the counter's `clear`, `count_enable` and `rollover_val`, watches `rollover_flag`, and returns a one-cycle `done` pulse. It sits between the requesting control logic and a single `flex_counter` in the same design level.

---
 rtl/flex_counter_sched.sv | 121 ++++++++++++
 tb/tb_flex_counter_sched.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/flex_counter_sched.sv
// Round-robin sequencer that lends a single flex_counter to NUM_REQ requesters
// as a programmable-interval timer, pulsing done to the owner on rollover.
module flex_counter_sched #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_BITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*NUM_BITS-1:0] period,
  output logic [NUM_REQ-1:0]          grant,
  output logic [NUM_REQ-1:0]          done,
  output logic                        busy,
  output logic                        cnt_clear,
  output logic                        cnt_enable,
  output logic [NUM_BITS-1:0]         cnt_rollover_val,
  input  logic                        cnt_rollover_flag
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0]   NUM_REQ_W = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, COUNT, DONE} state_t;

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    owner_reg, owner_next;
  logic [IDX_W-1:0]    last_reg, last_next;
  logic [NUM_BITS-1:0] rv_reg, rv_next;
  logic [IDX_W-1:0]    winner;
  logic                found;
  logic [IDX_W:0]      cand;
  logic [NUM_BITS-1:0] period_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_period
      assign period_arr[gi] = period[gi*NUM_BITS +: NUM_BITS];
    end
  endgenerate

  // Search starts one past the last served requester and wraps, so the
  // requester just served has lowest priority on the next arbitration.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = '0;
    for (int j = 1; j <= NUM_REQ; j++) begin
      cand = {1'b0, last_reg} + (IDX_W+1)'(j);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!found && req[cand[IDX_W-1:0]]) begin
        winner = cand[IDX_W-1:0];
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      owner_reg <= '0;
      last_reg  <= LAST_INIT;
      rv_reg    <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      rv_reg    <= rv_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    rv_next    = rv_reg;
    grant      = '0;
    done       = '0;
    busy       = 1'b1;
    cnt_clear  = 1'b0;
    cnt_enable = 1'b0;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (found) begin
          owner_next = winner;
          // A zero interval would never match a freshly cleared counter's
          // first increment, so it is promoted to the shortest legal interval.
          rv_next    = (period_arr[winner] == '0) ? NUM_BITS'(1) : period_arr[winner];
          state_next = CLEAR;
        end
      end
      CLEAR: begin
        grant[owner_reg] = 1'b1;
        cnt_clear        = 1'b1;
        state_next       = COUNT;
      end
      COUNT: begin
        grant[owner_reg] = 1'b1;
        cnt_enable       = ~cnt_rollover_flag;
        if (cnt_rollover_flag) begin
          state_next = DONE;
        end else if (!req[owner_reg]) begin
          last_next  = owner_reg;
          state_next = IDLE;
        end
      end
      DONE: begin
        grant[owner_reg] = 1'b1;
        done[owner_reg]  = 1'b1;
        cnt_clear        = 1'b1;
        last_next        = owner_reg;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cnt_rollover_val = rv_reg;

endmodule

// File: tb/tb_flex_counter_sched.sv
// Bench for flex_counter_sched: models the shared flex_counter and predicts
// grant order and done timing from the arbitration and interval rules.
module tb_flex_counter_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] period;
  logic [3:0]  grant, done;
  logic        busy, cnt_clear, cnt_enable, cnt_rollover_flag;
  logic [3:0]  cnt_rollover_val;
  logic [3:0]  cnt_q;

  int n_cmp = 0;
  int n_bad = 0;

  logic [3:0] grant_log [256];
  logic [3:0] done_log  [256];
  logic [3:0] rv_log    [256];
  logic [3:0] cnt_log   [256];
  logic       clear_log [256];
  logic       enable_log[256];
  logic       busy_log  [256];

  flex_counter_sched #(.NUM_REQ(4), .NUM_BITS(4)) dut (
    .clk(clk), .rst(rst), .req(req), .period(period),
    .grant(grant), .done(done), .busy(busy),
    .cnt_clear(cnt_clear), .cnt_enable(cnt_enable),
    .cnt_rollover_val(cnt_rollover_val), .cnt_rollover_flag(cnt_rollover_flag)
  );

  // Behavioural flex_counter, nrst tied to ~rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (cnt_clear) cnt_q <= '0;
    else if (cnt_enable) cnt_q <= (cnt_q == cnt_rollover_val) ? 4'd1 : cnt_q + 4'd1;
  end
  assign cnt_rollover_flag = (cnt_q == cnt_rollover_val);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int oh2idx(input logic [3:0] v);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  // Index t holds the outputs after the (t+1)-th rising edge following the call.
  task automatic observe(input int n, input bit drop_on_done, input bit scramble,
                         input int drop_at, input logic [3:0] drop_mask);
    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      grant_log[t]  = grant;   done_log[t]   = done;     rv_log[t]   = cnt_rollover_val;
      cnt_log[t]    = cnt_q;   clear_log[t]  = cnt_clear; enable_log[t] = cnt_enable;
      busy_log[t]   = busy;
      if (drop_on_done) req = req & ~done;
      if (t == drop_at) req = req & ~drop_mask;
      if (scramble && grant != 4'b0 && (t == 0 || grant_log[t-1] == 4'b0))
        for (int i = 0; i < 4; i++) if (grant[i]) period[i*4 +: 4] = 4'($urandom);
    end
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 4'hF;
    period = 16'h3333;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (grant !== 4'b0) begin n_bad++; $display("FAIL reset_grant: got %b want 0000", grant); end
      n_cmp++; if (done !== 4'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0000", done); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_cmp++; if ({cnt_clear, cnt_enable} !== 2'b00) begin n_bad++; $display("FAIL reset_cnt_ctrl: got %b want 00", {cnt_clear, cnt_enable}); end
      n_cmp++; if (cnt_rollover_val !== 4'd0) begin n_bad++; $display("FAIL reset_rv: got %0d want 0", cnt_rollover_val); end
    end
    rst = 1'b0;
    observe(2, 1'b0, 1'b0, -1, 4'b0);
    n_cmp++; if (grant_log[0] !== 4'b0001) begin n_bad++; $display("FAIL reset_first_grant: got %b want 0001", grant_log[0]); end
    $display("reset: first grant %b", grant_log[0]);
  endtask

  task automatic test_single();
    int ng, nd, nc, d_at;
    do_reset();
    period = 16'h0005;
    req = 4'b0001;
    observe(12, 1'b1, 1'b0, -1, 4'b0);
    ng = 0; nd = 0; nc = 0; d_at = -1;
    for (int t = 0; t < 12; t++) begin
      if (grant_log[t][0]) ng++;
      if (done_log[t] != 4'b0) begin nd++; if (d_at < 0) d_at = t; end
      if (clear_log[t]) nc++;
    end
    n_cmp++; if (grant_log[0] !== 4'b0001) begin n_bad++; $display("FAIL single_grant: got %b want 0001", grant_log[0]); end
    n_cmp++; if (rv_log[0] !== 4'd5) begin n_bad++; $display("FAIL single_rv: got %0d want 5", rv_log[0]); end
    n_cmp++; if (ng != 8) begin n_bad++; $display("FAIL single_grant_cycles: got %0d want 8", ng); end
    n_cmp++; if (d_at != 7) begin n_bad++; $display("FAIL single_done_time: got %0d want 7", d_at); end
    n_cmp++; if (nd != 1) begin n_bad++; $display("FAIL single_done_count: got %0d want 1", nd); end
    n_cmp++; if (done_log[7] !== 4'b0001) begin n_bad++; $display("FAIL single_done_bit: got %b want 0001", done_log[7]); end
    n_cmp++; if (nc != 2 || clear_log[0] !== 1'b1) begin n_bad++; $display("FAIL single_clear: got count %0d first %b want 2 1", nc, clear_log[0]); end
    n_cmp++; if (enable_log[1] !== 1'b1) begin n_bad++; $display("FAIL single_enable_on: got %b want 1", enable_log[1]); end
    n_cmp++; if (enable_log[6] !== 1'b0) begin n_bad++; $display("FAIL single_enable_freeze: got %b want 0", enable_log[6]); end
    n_cmp++; if (cnt_log[6] !== 4'd5 || cnt_log[7] !== 4'd5) begin n_bad++; $display("FAIL single_hold: got %0d %0d want 5 5", cnt_log[6], cnt_log[7]); end
    n_cmp++; if (grant_log[8] !== 4'b0 || grant_log[9] !== 4'b0) begin n_bad++; $display("FAIL single_idle: got %b %b want 0000 0000", grant_log[8], grant_log[9]); end
    $display("single: owner 0 period 5 done at %0d", d_at);
  endtask

  task automatic test_round_robin();
    int ns;
    int d_cnt [4];
    do_reset();
    period = 16'h2222;
    req = 4'hF;
    observe(30, 1'b0, 1'b0, -1, 4'b0);
    ns = 0;
    for (int i = 0; i < 4; i++) d_cnt[i] = 0;
    for (int t = 0; t < 30; t++) begin
      if (grant_log[t] != 4'b0 && (t == 0 || grant_log[t-1] == 4'b0)) begin
        if (ns < 5) begin
          n_cmp++; if (oh2idx(grant_log[t]) != (ns % 4) || t != ns * 6) begin
            n_bad++; $display("FAIL rr_job%0d: got owner %0d at %0d want owner %0d at %0d", ns, oh2idx(grant_log[t]), t, ns % 4, ns * 6);
          end
        end
        ns++;
      end
      for (int i = 0; i < 4; i++) if (done_log[t][i]) d_cnt[i]++;
    end
    n_cmp++; if (ns != 5) begin n_bad++; $display("FAIL rr_jobs: got %0d want 5", ns); end
    n_cmp++; if (d_cnt[0] != 2 || d_cnt[1] != 1 || d_cnt[2] != 1 || d_cnt[3] != 1) begin
      n_bad++; $display("FAIL rr_done_counts: got %0d %0d %0d %0d want 2 1 1 1", d_cnt[0], d_cnt[1], d_cnt[2], d_cnt[3]);
    end
    $display("round_robin: %0d job starts", ns);
  endtask

  task automatic test_zero_period();
    do_reset();
    period = 16'h0000;
    req = 4'b0010;
    observe(6, 1'b1, 1'b0, -1, 4'b0);
    n_cmp++; if (grant_log[0] !== 4'b0010) begin n_bad++; $display("FAIL zero_grant: got %b want 0010", grant_log[0]); end
    n_cmp++; if (rv_log[0] !== 4'd1) begin n_bad++; $display("FAIL zero_rv: got %0d want 1", rv_log[0]); end
    n_cmp++; if (done_log[3] !== 4'b0010 || done_log[2] !== 4'b0) begin n_bad++; $display("FAIL zero_done: got %b at 3, %b at 2 want 0010, 0000", done_log[3], done_log[2]); end
    $display("zero_period: owner 1 done %b", done_log[3]);
  endtask

  task automatic test_abort();
    int d2;
    do_reset();
    period = 16'h3900;
    req = 4'b1100;
    observe(16, 1'b1, 1'b0, 5, 4'b0100);
    d2 = 0;
    for (int t = 0; t < 16; t++) if (done_log[t][2]) d2++;
    n_cmp++; if (grant_log[0] !== 4'b0100) begin n_bad++; $display("FAIL abort_grant: got %b want 0100", grant_log[0]); end
    n_cmp++; if (cnt_log[5] !== 4'd4) begin n_bad++; $display("FAIL abort_count: got %0d want 4", cnt_log[5]); end
    n_cmp++; if (grant_log[6] !== 4'b0 || busy_log[6] !== 1'b0 || enable_log[6] !== 1'b0) begin
      n_bad++; $display("FAIL abort_idle: got grant %b busy %b en %b want 0000 0 0", grant_log[6], busy_log[6], enable_log[6]);
    end
    n_cmp++; if (d2 != 0) begin n_bad++; $display("FAIL abort_no_done: got %0d want 0", d2); end
    n_cmp++; if (grant_log[7] !== 4'b1000) begin n_bad++; $display("FAIL abort_next: got %b want 1000", grant_log[7]); end
    n_cmp++; if (done_log[12] !== 4'b1000) begin n_bad++; $display("FAIL abort_next_done: got %b want 1000", done_log[12]); end
    $display("abort: next grant %b", grant_log[7]);
  endtask

  task automatic test_reset_mid_count();
    int nd, d_at;
    do_reset();
    period = 16'h00A0;
    req = 4'b0010;
    for (int t = 0; t < 5; t++) @(negedge clk);
    n_cmp++; if (cnt_q !== 4'd3 || grant !== 4'b0010) begin n_bad++; $display("FAIL midrst_pre: got cnt %0d grant %b want 3 0010", cnt_q, grant); end
    rst = 1'b1;
    #1;
    n_cmp++; if ({grant, done, busy, cnt_clear, cnt_enable, cnt_rollover_val} !== 15'b0) begin
      n_bad++; $display("FAIL midrst_outputs: got grant %b done %b busy %b clr %b en %b rv %0d want all 0", grant, done, busy, cnt_clear, cnt_enable, cnt_rollover_val);
    end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (done !== 4'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL midrst_hold: got done %b busy %b want 0000 0", done, busy); end
    rst = 1'b0;
    observe(16, 1'b1, 1'b0, -1, 4'b0);
    nd = 0; d_at = -1;
    for (int t = 0; t < 16; t++) if (done_log[t] != 4'b0) begin nd++; if (d_at < 0) d_at = t; end
    n_cmp++; if (grant_log[0] !== 4'b0010 || rv_log[0] !== 4'd10) begin n_bad++; $display("FAIL midrst_regrant: got %b rv %0d want 0010 10", grant_log[0], rv_log[0]); end
    n_cmp++; if (d_at != 12 || nd != 1) begin n_bad++; $display("FAIL midrst_done: got at %0d count %0d want 12 1", d_at, nd); end
    $display("reset_mid_count: fresh job done at %0d", d_at);
  endtask

  task automatic test_random();
    int model_last, tend, nj, ns, nd, w, p;
    logic [3:0] mask, pending;
    int per [4];
    int exp_owner [4], exp_start [4], exp_done [4];
    int obs_owner [4], obs_start [4], obs_done [4];
    do_reset();
    model_last = 3;
    for (int r = 0; r < 8; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        per[i] = $urandom_range(0, 15);
        period[i*4 +: 4] = 4'(per[i]);
      end
      pending = mask; tend = 0; nj = 0;
      while (pending != 4'b0) begin
        w = -1;
        for (int j = 1; j <= 4; j++) if (w < 0 && pending[(model_last + j) % 4]) w = (model_last + j) % 4;
        p = (per[w] == 0) ? 1 : per[w];
        exp_owner[nj] = w; exp_start[nj] = tend; exp_done[nj] = tend + p + 2;
        pending[w] = 1'b0; model_last = w; tend = tend + p + 4; nj++;
      end
      req = mask;
      observe(tend + 2, 1'b1, 1'b1, -1, 4'b0);
      ns = 0; nd = 0;
      for (int t = 0; t < tend + 2; t++) begin
        if (grant_log[t] != 4'b0 && (t == 0 || grant_log[t-1] == 4'b0)) begin
          if (ns < 4) begin obs_owner[ns] = oh2idx(grant_log[t]); obs_start[ns] = t; end
          ns++;
        end
        if (done_log[t] != 4'b0) begin
          if (nd < 4) obs_done[nd] = t;
          nd++;
        end
      end
      n_cmp++; if (ns != nj || nd != nj) begin n_bad++; $display("FAIL rand%0d_jobs: got %0d starts %0d dones want %0d", r, ns, nd, nj); end
      for (int k = 0; k < nj && k < ns && k < nd; k++) begin
        n_cmp++; if (obs_owner[k] != exp_owner[k] || obs_start[k] != exp_start[k] || obs_done[k] != exp_done[k]) begin
          n_bad++; $display("FAIL rand%0d_job%0d: got owner %0d start %0d done %0d want %0d %0d %0d", r, k, obs_owner[k], obs_start[k], obs_done[k], exp_owner[k], exp_start[k], exp_done[k]);
        end
        $display("rand%0d job%0d: owner %0d start %0d done %0d", r, k, obs_owner[k], obs_start[k], obs_done[k]);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = '0;
    period = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_zero_period();
    test_abort();
    test_reset_mid_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
